// File: rtl/fifo_pkg.sv
// Shared pointer helpers for both sides of the async FIFO.
// The Gray conversions are width-generic: callers cast in and out of MAXW bits.
package fifo_pkg;

    localparam int MAXW = 32;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [MAXW-1:0] bin2gray(input logic [MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // XOR prefix from the MSB down; leading zeros leave the low bits unaffected
    function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
        logic [MAXW-1:0] b;
        b[MAXW-1] = g[MAXW-1];
        for (int i = MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into CLK.
// Every stage clears asynchronously so both FIFO sides restart from pointer 0.
module fifo_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DATA,
    output logic [WIDTH-1:0] SYNC
);

    logic [WIDTH-1:0] stage_reg [STAGES];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= DATA;
            for (int i = 1; i < STAGES; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign SYNC = stage_reg[STAGES-1];

endmodule

// File: rtl/fifo_wrptr_full.sv
// Write-side pointer, Gray pointer and full/almost-full/level logic of the async FIFO.
// All state is clocked by W_CLK; the incoming read pointer is synchronised here.
module fifo_wrptr_full
    import fifo_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 2
) (
    input  logic                     W_CLK,
    input  logic                     W_RST,
    input  logic                     W_INC,
    input  logic [$clog2(DEPTH):0]   gray_Rptr,
    output logic                     WFULL,
    output logic                     WALMOST_FULL,
    output logic [$clog2(DEPTH):0]   WLEVEL,
    output logic [$clog2(DEPTH)-1:0] Waddr,
    output logic [$clog2(DEPTH):0]   gray_Wptr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [AW:0] AF_LEVEL = PW'(DEPTH - AF_THRESH);

    logic [AW:0] wptr_reg;
    logic [AW:0] wptr_next;
    logic [AW:0] gray_wptr_reg;
    logic [AW:0] rq;
    logic [AW:0] rbin;
    logic [AW:0] level;
    logic        wr_en;

    fifo_ptr_sync #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .CLK  (W_CLK),
        .RST  (W_RST),
        .DATA (gray_Rptr),
        .SYNC (rq)
    );

    assign rbin      = PW'(gray2bin(MAXW'(rq)));
    assign wr_en     = W_INC & ~WFULL;
    assign wptr_next = wptr_reg + {{AW{1'b0}}, wr_en};

    // Gray register loads from the next binary value so it never lags wptr_reg
    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            wptr_reg      <= '0;
            gray_wptr_reg <= '0;
        end else begin
            wptr_reg      <= wptr_next;
            gray_wptr_reg <= PW'(bin2gray(MAXW'(wptr_next)));
        end
    end

    assign WFULL        = (wptr_reg[AW] != rbin[AW]) && (wptr_reg[AW-1:0] == rbin[AW-1:0]);
    assign level        = wptr_reg - rbin;
    assign WLEVEL       = level;
    assign WALMOST_FULL = (level >= AF_LEVEL);
    assign Waddr        = wptr_reg[AW-1:0];
    assign gray_Wptr    = gray_wptr_reg;

endmodule

// File: tb/tb_fifo_wrptr_full.sv
// Directed scoreboard bench for the write-side pointer/full block (DEPTH=16).
// Stimulus pushes expected outputs; a monitor pops and compares on each falling edge.
module tb_fifo_wrptr_full;

    logic       W_CLK = 1'b0;
    logic       W_RST = 1'b0;
    logic       W_INC = 1'b0;
    logic [4:0] gray_Rptr = 5'd0;
    logic       WFULL;
    logic       WALMOST_FULL;
    logic [4:0] WLEVEL;
    logic [3:0] Waddr;
    logic [4:0] gray_Wptr;

    fifo_wrptr_full #(
        .DEPTH       (16),
        .SYNC_STAGES (2),
        .AF_THRESH   (2)
    ) dut (
        .W_CLK        (W_CLK),
        .W_RST        (W_RST),
        .W_INC        (W_INC),
        .gray_Rptr    (gray_Rptr),
        .WFULL        (WFULL),
        .WALMOST_FULL (WALMOST_FULL),
        .WLEVEL       (WLEVEL),
        .Waddr        (Waddr),
        .gray_Wptr    (gray_Wptr)
    );

    always #5 W_CLK = ~W_CLK;

    typedef struct {
        string      name;
        logic [3:0] waddr;
        logic [4:0] gray;
        logic       full;
        logic       af;
        logic [4:0] lvl;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    logic mon_trig = 1'b0;

    function automatic logic [4:0] g5(input int n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    function automatic exp_t mk(input string nm, input int wp, input int lvl);
        exp_t x;
        x.name  = nm;
        x.waddr = 4'(wp % 16);
        x.gray  = g5(wp);
        x.full  = (lvl == 16);
        x.af    = (lvl >= 14);
        x.lvl   = 5'(lvl);
        return x;
    endfunction

    // One clock: drive inputs, expect the given write pointer and level after the edge
    task automatic cyc(input logic inc, input logic [4:0] rp, input string nm,
                       input int wp, input int lvl);
        W_INC     = inc;
        gray_Rptr = rp;
        @(posedge W_CLK);
        exp_q.push_back(mk(nm, wp, lvl));
        @(negedge W_CLK);
    endtask

    always @(negedge W_CLK or posedge mon_trig) begin
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (Waddr !== e.waddr || gray_Wptr !== e.gray || WFULL !== e.full ||
                WALMOST_FULL !== e.af || WLEVEL !== e.lvl) begin
                errors++;
                $display("FAIL %s: got waddr=%0d gray=%b full=%b af=%b lvl=%0d, want waddr=%0d gray=%b full=%b af=%b lvl=%0d",
                         e.name, Waddr, gray_Wptr, WFULL, WALMOST_FULL, WLEVEL,
                         e.waddr, e.gray, e.full, e.af, e.lvl);
            end else begin
                $display("[%0t] %s waddr=%0d gray=%b full=%b af=%b lvl=%0d ok",
                         $time, e.name, Waddr, gray_Wptr, WFULL, WALMOST_FULL, WLEVEL);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with a write request pending
        cyc(1'b1, 5'd0, "reset", 0, 0);
        cyc(1'b1, 5'd0, "reset", 0, 0);
        W_RST = 1'b1;

        // Fill all 16 entries against an empty read side
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 5'd0, "fill", i, i);
        end

        // Requests while full are ignored
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 5'd0, "overflow", 16, 16);
        end

        // Read side frees one entry: visible after exactly two edges
        cyc(1'b0, 5'b00001, "release_e1", 16, 16);
        cyc(1'b0, 5'b00001, "release_e2", 16, 15);
        cyc(1'b1, 5'b00001, "refill", 17, 16);

        // Move read pointer to bin 16, then write up to Wptr=31 and across the wrap
        cyc(1'b0, 5'b11000, "rd16_e1", 17, 16);
        cyc(1'b0, 5'b11000, "rd16_e2", 17, 1);
        for (int n = 18; n <= 31; n++) begin
            cyc(1'b1, 5'b11000, "pre_wrap", n, n - 16);
        end
        cyc(1'b1, 5'b11000, "wrap", 0, 16);

        // Read pointer bin 23 -> level 9, then asynchronous reset between edges
        cyc(1'b0, 5'b11100, "lvl9_e1", 0, 16);
        cyc(1'b0, 5'b11100, "lvl9_e2", 0, 9);
        #2;
        W_RST = 1'b0;
        #1;
        exp_q.push_back(mk("async_rst", 0, 0));
        mon_trig = 1'b1;
        #1;
        mon_trig  = 1'b0;
        gray_Rptr = 5'd0;
        W_RST     = 1'b1;

        // Writes resume from address 0
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 5'd0, "resume", i, i);
        end
        W_INC = 1'b0;

        @(negedge W_CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
